// File: rtl/prbs_checker.sv
// PRBS receive checker: self-synchronising LFSR predictor with lock/flywheel and error counting.
// Optional macro PRBS_CHECKER_INV_EN adds an 'inv' input that inverts din before use.
module prbs_checker #(
  parameter int unsigned WIDTH    = 7,
  parameter int unsigned TAP      = 6,
  parameter int unsigned LOCK_CNT = 16,
  parameter int unsigned LOSS_ERR = 4,
  parameter int unsigned ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
`ifdef PRBS_CHECKER_INV_EN
  input  logic             inv,
`endif
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int unsigned CNT_MAX = (WIDTH > LOCK_CNT) ? WIDTH : LOCK_CNT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned WIN_W   = $clog2(LOSS_ERR + 1);

  typedef enum logic [1:0] {
    S_SEARCH,
    S_VERIFY,
    S_LOCKED
  } state_t;

  state_t             r_state, w_state_nx;
  logic [WIDTH-1:0]   r_sr, w_sr_nx;
  logic [CNT_W-1:0]   r_fill, w_fill_nx;
  logic [CNT_W-1:0]   r_match, w_match_nx;
  logic [WIN_W-1:0]   r_win, w_win_nx;
  logic               r_err_pulse, w_err_pulse_nx;
  logic [ERR_W-1:0]   r_err_cnt, w_err_cnt_nx;

  logic               w_din;
  logic               w_pred;
  logic               w_mis;
  logic [WIDTH-1:0]   w_sr_din;
  logic [WIDTH-1:0]   w_sr_pred;

`ifdef PRBS_CHECKER_INV_EN
  assign w_din = din ^ inv;
`else
  assign w_din = din;
`endif

  assign w_pred    = r_sr[WIDTH-1] ^ r_sr[TAP-1];
  assign w_mis     = (w_din != w_pred);
  assign w_sr_din  = {r_sr[WIDTH-2:0], w_din};
  assign w_sr_pred = {r_sr[WIDTH-2:0], w_pred};

  always_comb begin
    w_state_nx     = r_state;
    w_sr_nx        = r_sr;
    w_fill_nx      = r_fill;
    w_match_nx     = r_match;
    w_win_nx       = r_win;
    w_err_pulse_nx = 1'b0;
    w_err_cnt_nx   = r_err_cnt;

    if (en) begin
      case (r_state)
        S_SEARCH: begin
          w_sr_nx = w_sr_din;
          // Fill saturates at WIDTH so an all-zero register keeps re-checking without refilling.
          if (r_fill >= CNT_W'(WIDTH - 1)) begin
            w_fill_nx = CNT_W'(WIDTH);
            if (|w_sr_din) begin
              w_state_nx = S_VERIFY;
              w_match_nx = '0;
            end
          end else begin
            w_fill_nx = r_fill + CNT_W'(1);
          end
        end

        S_VERIFY: begin
          w_sr_nx = w_sr_din;
          if (w_mis || !(|w_sr_din)) begin
            w_state_nx = S_SEARCH;
            w_fill_nx  = '0;
            w_match_nx = '0;
          end else if (r_match == CNT_W'(LOCK_CNT - 1)) begin
            w_state_nx = S_LOCKED;
            w_match_nx = '0;
            w_win_nx   = '0;
          end else begin
            w_match_nx = r_match + CNT_W'(1);
          end
        end

        S_LOCKED: begin
          // Flywheel: predicted bit is fed back so a single flipped bit counts once.
          w_sr_nx = w_sr_pred;
          if (w_mis) begin
            w_err_pulse_nx = 1'b1;
            if (r_err_cnt != '1) begin
              w_err_cnt_nx = r_err_cnt + ERR_W'(1);
            end
            w_match_nx = '0;
            if (r_win == WIN_W'(LOSS_ERR - 1)) begin
              w_state_nx = S_SEARCH;
              w_fill_nx  = '0;
              w_win_nx   = '0;
            end else begin
              w_win_nx = r_win + WIN_W'(1);
            end
          end else if (r_match == CNT_W'(LOCK_CNT - 1)) begin
            w_match_nx = '0;
            w_win_nx   = '0;
          end else begin
            w_match_nx = r_match + CNT_W'(1);
          end
        end

        default: begin
          w_state_nx = S_SEARCH;
          w_fill_nx  = '0;
          w_match_nx = '0;
          w_win_nx   = '0;
        end
      endcase
    end

    if (clr) begin
      w_err_cnt_nx = '0;
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      r_state     <= S_SEARCH;
      r_sr        <= '0;
      r_fill      <= '0;
      r_match     <= '0;
      r_win       <= '0;
      r_err_pulse <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_sr        <= w_sr_nx;
      r_fill      <= w_fill_nx;
      r_match     <= w_match_nx;
      r_win       <= w_win_nx;
      r_err_pulse <= w_err_pulse_nx;
      r_err_cnt   <= w_err_cnt_nx;
    end
  end

  assign locked    = (r_state == S_LOCKED);
  assign err_pulse = r_err_pulse;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed self-checking bench for prbs_checker (default parameters, PRBS7 seed 7'h7F).
module tb_prbs_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        din;
  logic        clr;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_cnt;
`ifdef PRBS_CHECKER_INV_EN
  logic        inv = 1'b0;
`endif

  int          n_checks = 0;
  int          n_err    = 0;
  logic [6:0]  g;

  prbs_checker #(
    .WIDTH    (7),
    .TAP      (6),
    .LOCK_CNT (16),
    .LOSS_ERR (4),
    .ERR_W    (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .din       (din),
`ifdef PRBS_CHECKER_INV_EN
    .inv       (inv),
`endif
    .clr       (clr),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic next_bit(output logic b);
    b = g[6] ^ g[5];
    g = {g[5:0], b};
  endtask

  task automatic cyc(input logic e, input logic d, input logic c);
    en  = e;
    din = d;
    clr = c;
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic flip);
    logic b;
    next_bit(b);
    cyc(1'b1, b ^ flip, 1'b0);
  endtask

  initial begin
    int   lock_at;
    int   pulses;
    int   drops;
    int   lock_seen;
    logic b;

    rst = 1'b1; en = 1'b1; din = 1'b1; clr = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_locked", 32'(locked), 0);
    check("rst_pulse", 32'(err_pulse), 0);
    check("rst_errcnt", 32'(err_cnt), 0);
    rst = 1'b0;

    // Clean stream from reset
    g = 7'h7F; lock_at = 0; pulses = 0;
    for (int i = 1; i <= 300; i++) begin
      send(1'b0);
      if (locked && lock_at == 0) lock_at = i;
      pulses += int'(err_pulse);
    end
    check("clean_lock_bit", 32'(lock_at), 23);
    check("clean_pulses", 32'(pulses), 0);
    check("clean_errcnt", 32'(err_cnt), 0);
    check("clean_locked", 32'(locked), 1);

    // Single flipped bit while locked
    pulses = 0; drops = 0;
    for (int i = 1; i <= 150; i++) begin
      send(i == 100);
      if (i == 100) check("flip1_pulse", 32'(err_pulse), 1);
      if (i == 101) check("flip1_pulse_end", 32'(err_pulse), 0);
      pulses += int'(err_pulse);
      if (!locked) drops++;
    end
    check("flip1_pulses", 32'(pulses), 1);
    check("flip1_errcnt", 32'(err_cnt), 1);
    check("flip1_drops", 32'(drops), 0);

    // Clear, then four errors within ten bits
    next_bit(b);
    cyc(1'b1, b, 1'b1);
    check("clr_errcnt", 32'(err_cnt), 0);
    repeat (20) send(1'b0);
    for (int i = 0; i <= 9; i++) begin
      send((i % 3) == 0);
      if (i == 6) check("burst_still_locked", 32'(locked), 1);
    end
    check("burst_loss", 32'(locked), 0);
    check("burst_errcnt", 32'(err_cnt), 4);
    lock_at = 0;
    for (int i = 1; i <= 40; i++) begin
      send(1'b0);
      if (locked && lock_at == 0) lock_at = i;
    end
    check("relock_bit", 32'(lock_at), 23);
    check("relock_errcnt", 32'(err_cnt), 4);

    // Stuck-at-0 stream
    rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    check("rst2_errcnt", 32'(err_cnt), 0);
    lock_seen = 0;
    repeat (200) begin
      cyc(1'b1, 1'b0, 1'b0);
      lock_seen += int'(locked);
    end
    check("stuck0_lock", 32'(lock_seen), 0);
    check("stuck0_errcnt", 32'(err_cnt), 0);

    // Stuck-at-1 stream
    rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    lock_seen = 0;
    repeat (200) begin
      cyc(1'b1, 1'b1, 1'b0);
      lock_seen += int'(locked);
    end
    check("stuck1_lock", 32'(lock_seen), 0);
    check("stuck1_errcnt", 32'(err_cnt), 0);

    // en alternating, with wrong bits on the idle cycles
    rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    g = 7'h7F; lock_at = 0; pulses = 0; drops = 0;
    for (int v = 1; v <= 40; v++) begin
      send(1'b0);
      if (locked && lock_at == 0) lock_at = v;
      pulses += int'(err_pulse);
      cyc(1'b0, ~(g[6] ^ g[5]), 1'b0);
      pulses += int'(err_pulse);
      if (lock_at != 0 && !locked) drops++;
    end
    check("en_lock_bit", 32'(lock_at), 23);
    check("en_pulses", 32'(pulses), 0);
    check("en_drops", 32'(drops), 0);
    check("en_errcnt", 32'(err_cnt), 0);

    // Accumulate five spaced errors, then clr coinciding with an error
    for (int k = 0; k < 5; k++) begin
      send(1'b1);
      repeat (20) send(1'b0);
    end
    check("five_errcnt", 32'(err_cnt), 5);
    check("five_locked", 32'(locked), 1);
    next_bit(b);
    cyc(1'b1, ~b, 1'b1);
    check("clr_err_cnt", 32'(err_cnt), 0);
    check("clr_err_pulse", 32'(err_pulse), 1);
    check("clr_locked", 32'(locked), 1);

    // Reset while locked
    repeat (5) send(1'b0);
    send(1'b1);
    check("pre_rst_errcnt", 32'(err_cnt), 1);
    check("pre_rst_pulse", 32'(err_pulse), 1);
    rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    check("midlock_rst_locked", 32'(locked), 0);
    check("midlock_rst_errcnt", 32'(err_cnt), 0);
    check("midlock_rst_pulse", 32'(err_pulse), 0);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
